// File: rtl/adder_pkg.sv
// Shared constants and helpers for the registered adder.
// The carry-lookahead build is selected by defining ADDER_CLA_EN.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 32;
  localparam int CLA_GROUP           = 4;

  // Signed overflow: operands share a sign and the sum's sign differs from it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage : adder_pkg

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: generate/propagate per bit, all internal
// carries computed directly from cin, group carry out for rippling onward.
// Only instantiated when ADDER_CLA_EN is defined.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead equations so no carry depends on a neighbour's carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule : cla_group4

// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry out and signed overflow, one-cycle
// latency, full throughput. Define ADDER_CLA_EN to build the combinational
// sum from 4-bit carry-lookahead groups; otherwise a ripple-carry chain.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

`ifdef ADDER_CLA_EN
  localparam int NGROUPS = (WIDTH + CLA_GROUP - 1) / CLA_GROUP;
  localparam int PWIDTH  = NGROUPS * CLA_GROUP;

  logic [PWIDTH-1:0] a_pad;
  logic [PWIDTH-1:0] b_pad;
  logic [PWIDTH-1:0] sum_pad;
  logic [NGROUPS:0]  gcarry;
  logic [PWIDTH:0]   total;

  // Zero padding the last partial group means the pad bit just above the
  // MSB receives exactly the carry out of bit WIDTH-1.
  assign a_pad     = PWIDTH'(a);
  assign b_pad     = PWIDTH'(b);
  assign gcarry[0] = 1'b0;

  for (genvar g = 0; g < NGROUPS; g++) begin : g_cla
    cla_group4 u_grp (
      .a    (a_pad[g*CLA_GROUP +: CLA_GROUP]),
      .b    (b_pad[g*CLA_GROUP +: CLA_GROUP]),
      .cin  (gcarry[g]),
      .sum  (sum_pad[g*CLA_GROUP +: CLA_GROUP]),
      .cout (gcarry[g+1])
    );
  end

  assign total            = {gcarry[NGROUPS], sum_pad};
  assign {cout_c, sum_c}  = total[WIDTH:0];
`else
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign sum_c[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout_c = carry[WIDTH];
`endif

  assign ovf_c = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum_c[WIDTH-1]);

  // Output stage: capture a result on each valid input, hold it otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_c;
        cout <= cout_c;
        ovf  <= ovf_c;
      end
    end
  end

endmodule : adder

// File: tb/tb_adder.sv
// Scoreboard bench for adder (WIDTH=32): the driver pushes expected results
// computed with wide integer arithmetic; an independent monitor pops and
// compares whenever the DUT presents out_valid.
module tb_adder;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  exp_t exp_q[$];

  adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: full 33-bit unsigned sum, overflow from the signed range.
  function automatic exp_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [W:0]  full;
    longint      s;
    full   = {1'b0, x} + {1'b0, y};
    s      = longint'($signed(x)) + longint'($signed(y));
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return e;
  endfunction

  // Present one input on the falling edge; valid inputs queue an expectation.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic v);
    @(negedge clk);
    in_valid = v;
    if (v) begin
      a = x;
      b = y;
      exp_q.push_back(ref_add(x, y));
    end else begin
      a = 'x;
      b = 'x;
    end
  endtask

  // Assert reset between edges, check the outputs clear at once, hold, release.
  task automatic do_reset(input int n);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_now_valid", 64'(out_valid), 64'd0);
    check("rst_now_sum",   64'(sum),       64'd0);
    check("rst_now_cout",  64'(cout),      64'd0);
    check("rst_now_ovf",   64'(ovf),       64'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: one look per cycle, just after the rising edge.
  initial begin : monitor
    exp_t last;
    exp_t e;
    last = '0;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_hold_valid", 64'(out_valid), 64'd0);
        check("rst_hold_out",   64'({sum, cout, ovf}), 64'd0);
        last = '0;
      end else begin
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sum",  64'(sum),  64'(e.sum));
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf",  64'(ovf),  64'(e.ovf));
          last = e;
        end else if (!out_valid) begin
          check("hold_sum",  64'(sum),  64'(last.sum));
          check("hold_flags", 64'({cout, ovf}), 64'({last.cout, last.ovf}));
        end
      end
    end
  end

  initial begin : driver
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    mon_en   = 1'b1;

    do_reset(3);

    send(32'h0000_0000, 32'h0000_0000, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    send('0, '0, 1'b0);
    send('0, '0, 1'b0);

    // Leave a nonzero result visible, then reset with one result in flight.
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    send(32'hDEAD_BEEF, 32'h0000_1111, 1'b1);
    do_reset(1);
    send(32'h0000_0001, 32'h0000_0002, 1'b1);
    send('0, '0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, ($urandom_range(0, 3) != 0));
    end
    send('0, '0, 1'b0);

    repeat (3) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder
